// File: rtl/sm_mul_seq.sv
// ----------------------------------------------------------------------------
// sm_mul_seq
//
// Sequential sign-magnitude shift-add multiplier. Two (N+1)-bit
// sign-magnitude operands are captured on an accepted start. The block then
// retires one multiplier bit per cycle for N cycles and presents a (2N+1)-bit
// sign-magnitude product. It uses the same operand format as the
// sign-magnitude divider beside it, and that divider checks its results
// against this block.
//
// Ports
//   clk           in   1      rising-edge clock
//   rst           in   1      synchronous, active-high reset
//   start         in   1      request; honoured only in IDLE or DONE
//   multiplicand  in   N+1    [N] sign, [N-1:0] magnitude
//   multiplier    in   N+1    [N] sign, [N-1:0] magnitude
//   busy          out  1      high while an operation is in progress
//   done          out  1      high while the product is valid
//   product       out  2N+1   [2N] sign, [2N-1:0] magnitude
// ----------------------------------------------------------------------------
module sm_mul_seq #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N:0]     multiplicand,
  input  logic [N:0]     multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*N:0]   product
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     m_q, m_d;          // multiplicand magnitude
  logic [N-1:0]     a_q, a_d;          // multiplier, shifted out LSB first
  logic [N:0]       p_q, p_d;          // partial product high half, with carry
  logic             s_q, s_d;          // product sign before zero correction
  logic [CW-1:0]    count_q, count_d;
  logic [2*N:0]     product_q, product_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept;
  logic             last_step;
  logic [N:0]       sum;
  logic [N:0]       p_shift;
  logic [N-1:0]     a_shift;
  logic [2*N-1:0]   mag;

  // start is honoured only when no operation is in flight.
  assign accept    = start && (state_q == IDLE || state_q == DONE);
  assign last_step = (state_q == CALC) && (count_q == CW'(N - 1));

  // One shift-add step. The sum fits in N+1 bits because P stays below 2^N
  // before the add. The whole {P,A} pair then shifts right, and the LSB of
  // the sum moves into the MSB of A.
  assign sum     = a_q[0] ? (p_q + {1'b0, m_q}) : p_q;
  assign p_shift = {1'b0, sum[N:1]};
  assign a_shift = {sum[0], a_q[N-1:1]};
  assign mag     = {p_shift[N-1:0], a_shift};

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  // NOTE: each combinational block assigns a default to every output first.
  // That way no path leaves a signal unassigned, and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)     state_d = CALC;
      CALC:    if (last_step) state_d = DONE;
      DONE:    if (start)     state_d = CALC;
      default:                state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath next-state
  // --------------------------------------------------------------------------
  always_comb begin
    m_d       = m_q;
    a_d       = a_q;
    p_d       = p_q;
    s_d       = s_q;
    count_d   = count_q;
    product_d = product_q;

    if (accept) begin
      m_d     = multiplicand[N-1:0];
      a_d     = multiplier[N-1:0];
      s_d     = multiplicand[N] ^ multiplier[N];
      p_d     = '0;
      count_d = '0;
    end else if (state_q == CALC) begin
      p_d     = p_shift;
      a_d     = a_shift;
      count_d = count_q + CW'(1);
      // A zero magnitude always gets a positive sign, so -0 is never output.
      if (last_step) begin
        product_d = {s_q & (|mag), mag};
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output decode. Outputs are registered, so they are decoded from the
  // next state and line up with the state register.
  // --------------------------------------------------------------------------
  always_comb begin
    busy_d = (state_d == CALC);
    done_d = (state_d == DONE);
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples its pre-edge value, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= '0;
      a_q       <= '0;
      p_q       <= '0;
      s_q       <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      a_q       <= a_d;
      p_q       <= p_d;
      s_q       <= s_d;
      count_q   <= count_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_sm_mul_seq.sv
// ----------------------------------------------------------------------------
// tb_sm_mul_seq
//
// Directed testbench for sm_mul_seq with N=16. Inputs are driven around the
// falling edge or just after the rising edge, and outputs are sampled on the
// falling edge. Every expected product below was computed by hand.
// ----------------------------------------------------------------------------
module tb_sm_mul_seq;

  localparam int N      = 16;
  localparam int BUDGET = 40;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [N:0]     multiplicand;
  logic [N:0]     multiplier;
  logic           busy;
  logic           done;
  logic [2*N:0]   product;

  int n_cmp = 0;
  int n_err = 0;

  sm_mul_seq #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  // Drive a one-cycle start pulse. Returns just after the accepting edge,
  // after dropping start and scrambling the operands.
  task automatic launch(input logic [N:0] mc, input logic [N:0] mp);
    @(negedge clk);
    multiplicand = mc;
    multiplier   = mp;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start        = 1'b0;
    multiplicand = 17'h1_5A5A;
    multiplier   = 17'h0_3C3C;
  endtask

  // Called just after an accepting edge. Counts how many later edges it takes
  // for done to be seen, and how many falling-edge samples had busy high
  // before that. edges = -1 if the budget runs out.
  task automatic wait_done(output int edges, output int busy_cnt);
    edges    = -1;
    busy_cnt = 0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        edges = i;
        break;
      end
      if (busy === 1'b1) busy_cnt++;
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    logic ok;
    rst          = 1'b1;
    start        = 1'b1;
    multiplicand = 17'($urandom);
    multiplier   = 17'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy, done, product} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: busy=%b done=%b product=%h, required 0 0 0",
               busy, done, product);
    end
    rst   = 1'b0;
    start = 1'b0;
    ok    = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if ({busy, done, product} !== '0) ok = 1'b0;
    end
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL reset_idle_hold: outputs left 0 while idle, busy=%b done=%b product=%h",
               busy, done, product);
    end
  endtask

  task automatic test_basic();
    int   edges, bc;
    logic ok;
    launch(17'h0_A0A0, 17'h0_1A1A);
    wait_done(edges, bc);
    n_cmp++;
    if (edges !== 16) begin
      n_err++;
      $display("FAIL basic_latency: done after %0d edges, required 16", edges);
    end
    n_cmp++;
    if (bc !== 16) begin
      n_err++;
      $display("FAIL basic_busy_cycles: busy seen %0d cycles, required 16", bc);
    end
    n_cmp++;
    if (product !== 33'h0_1060_9040 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_product: product=%h busy=%b, required 010609040 busy=0",
               product, busy);
    end
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (product !== 33'h0_1060_9040 || done !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL basic_hold: product=%h done=%b after idle, required 010609040 done=1",
               product, done);
    end
  endtask

  task automatic test_signs();
    logic [N:0]   mc  [3] = '{17'h1_0003, 17'h1_FFFF, 17'h1_1234};
    logic [N:0]   mp  [3] = '{17'h0_0005, 17'h1_FFFF, 17'h0_0000};
    logic [2*N:0] exp [3] = '{33'h1_0000_000F, 33'h0_FFFE_0001, 33'h0_0000_0000};
    int edges, bc;
    for (int k = 0; k < 3; k++) begin
      launch(mc[k], mp[k]);
      wait_done(edges, bc);
      n_cmp++;
      if (edges !== 16 || product !== exp[k]) begin
        n_err++;
        $display("FAIL signs_%0d: %h x %h gave %h after %0d edges, required %h after 16",
                 k, mc[k], mp[k], product, edges, exp[k]);
      end
    end
  endtask

  task automatic test_ignored_start();
    int edges, bc;
    // 255 x 257 = 65535, negative.
    launch(17'h0_00FF, 17'h1_0101);
    repeat (3) @(negedge clk);
    multiplicand = 17'h0_1111;
    multiplier   = 17'h0_2222;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(edges, bc);
    n_cmp++;
    if (edges !== 13) begin
      n_err++;
      $display("FAIL ignored_start_latency: done %0d edges after stray start, required 13",
               edges);
    end
    n_cmp++;
    if (product !== 33'h1_0000_FFFF) begin
      n_err++;
      $display("FAIL ignored_start_product: product=%h, required 10000ffff", product);
    end
  endtask

  task automatic test_back_to_back();
    logic [N:0]   mc  [3] = '{17'h0_0007, 17'h1_0100, 17'h0_8000};
    logic [N:0]   mp  [3] = '{17'h1_0009, 17'h1_0100, 17'h1_8000};
    logic [2*N:0] exp [3] = '{33'h1_0000_003F, 33'h0_0001_0000, 33'h1_4000_0000};
    int edges, bc;
    @(negedge clk);
    multiplicand = mc[0];
    multiplier   = mp[0];
    start        = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      // First pass: edges counts from the first accept, so the first result
      // needs 16 edges. Each later pass starts from the edge after done, so
      // 16 here is 17 edges between results.
      wait_done(edges, bc);
      if (k < 2) begin
        multiplicand = mc[k+1];
        multiplier   = mp[k+1];
      end else begin
        start = 1'b0;
      end
      n_cmp++;
      if (edges !== 16 || bc !== 16 || product !== exp[k]) begin
        n_err++;
        $display("FAIL b2b_%0d: product=%h edges=%0d busy=%0d, required %h 16 16",
                 k, product, edges, bc, exp[k]);
      end
      if (k < 2) @(posedge clk);
    end
  endtask

  task automatic test_mid_reset();
    int edges, bc;
    launch(17'h0_A0A0, 17'h0_1A1A);
    repeat (7) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset_busy_before: busy=%b, required 1", busy);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy, done, product} !== '0) begin
      n_err++;
      $display("FAIL mid_reset_clear: busy=%b done=%b product=%h, required 0 0 0",
               busy, done, product);
    end
    rst          = 1'b0;
    multiplicand = 17'h0_0002;
    multiplier   = 17'h0_0003;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(edges, bc);
    n_cmp++;
    if (edges !== 16 || product !== 33'h0_0000_0006) begin
      n_err++;
      $display("FAIL mid_reset_restart: product=%h after %0d edges, required 000000006 after 16",
               product, edges);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_ignored_start();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
